// File: rtl/cia_interrupt_if.sv
// Register-bus side of the CIA interrupt control register: PHI2 strobes,
// read/write access, the ICR read value and the IRQ pad drive.
interface cia_interrupt_if;
   logic       phi2_up;
   logic       phi2_dn;
   logic       we;
   logic       re;
   logic [3:0] addr;
   logic [7:0] data;
   logic [7:0] regs;
   logic       irq_n;

   modport master (
      output phi2_up,
      output phi2_dn,
      output we,
      output re,
      output addr,
      output data,
      input  regs,
      input  irq_n
   );

   modport slave (
      input  phi2_up,
      input  phi2_dn,
      input  we,
      input  re,
      input  addr,
      input  data,
      output regs,
      output irq_n
   );
endinterface

// File: rtl/cia_interrupt.sv
// CIA interrupt control register ($D): latches source pulses and FLAG falling edges, masks them
// and drives irq_n. Define CIA_ICR_DELAYED_IRQ_EN for the old 6526 one-PHI2-cycle-late IRQ.
module cia_interrupt (
   input logic             clk,
   input logic             res,
   cia_interrupt_if.slave  bus,
   input logic             ta_int,
   input logic             tb_int,
   input logic             alarm_int,
   input logic             sp_int,
   input logic             flag_n
);

   localparam logic [3:0] IcrAddr = 4'hD;

   logic       flag_meta_q;
   logic       flag_sync_q;
   logic       flag_prev_q;
   logic       flag_prev_d;
   logic [4:0] icr_q;
   logic [4:0] icr_d;
   logic [4:0] imr_q;
   logic [4:0] imr_d;
   logic       ir_q;
   logic       ir_d;
   logic       icr_sel;
   logic       rd_clr;
   logic       wr_mask;
   logic       flag_fall;
   logic [4:0] src;
   logic       unused_data;

   assign unused_data = ^bus.data[6:5];

   // FLAG pad is asynchronous; two flops before any use.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         flag_meta_q <= 1'b1;
         flag_sync_q <= 1'b1;
      end else begin
         flag_meta_q <= flag_n;
         flag_sync_q <= flag_meta_q;
      end
   end

   always_comb begin
      icr_sel     = (bus.addr == IcrAddr);
      rd_clr      = bus.phi2_dn & bus.re & icr_sel;
      wr_mask     = bus.phi2_dn & bus.we & icr_sel;
      flag_fall   = flag_prev_q & ~flag_sync_q;
      flag_prev_d = bus.phi2_dn ? flag_sync_q : flag_prev_q;
      src         = bus.phi2_dn ? {flag_fall, sp_int, alarm_int, tb_int, ta_int} : 5'b0;

      // A read clears everything except events arriving on the same strobe.
      icr_d = rd_clr ? src : (icr_q | src);

      imr_d = imr_q;
      if (wr_mask) begin
         if (bus.data[7]) begin
            imr_d = imr_q | bus.data[4:0];
         end else begin
            imr_d = imr_q & ~bus.data[4:0];
         end
      end

      ir_d = ir_q;
      if (rd_clr) begin
         ir_d = 1'b0;
      end else if (bus.phi2_up && (|(icr_q & imr_q))) begin
         ir_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         flag_prev_q <= 1'b1;
         icr_q       <= 5'b0;
         imr_q       <= 5'b0;
         ir_q        <= 1'b0;
      end else begin
         flag_prev_q <= flag_prev_d;
         icr_q       <= icr_d;
         imr_q       <= imr_d;
         ir_q        <= ir_d;
      end
   end

   assign bus.regs = {ir_q, 2'b00, icr_q};

`ifdef CIA_ICR_DELAYED_IRQ_EN
   logic ir_dly_q;
   logic ir_dly_d;

   always_comb begin
      ir_dly_d = ir_dly_q;
      if (rd_clr) begin
         ir_dly_d = 1'b0;
      end else if (bus.phi2_up) begin
         ir_dly_d = ir_q;
      end
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         ir_dly_q <= 1'b0;
      end else begin
         ir_dly_q <= ir_dly_d;
      end
   end

   assign bus.irq_n = ~ir_dly_q;
`else
   assign bus.irq_n = ~ir_q;
`endif

endmodule

// File: tb/tb_cia_interrupt.sv
// Self-checking bench for cia_interrupt: directed vector table, randomized PHI2 cycles against
// an event-level model, and an asynchronous mid-cycle reset sequence.
module tb_cia_interrupt;

   logic clk;
   logic res;
   logic ta_int;
   logic tb_int;
   logic alarm_int;
   logic sp_int;
   logic flag_n;

   cia_interrupt_if bus ();

   cia_interrupt dut (
      .clk       (clk),
      .res       (res),
      .bus       (bus),
      .ta_int    (ta_int),
      .tb_int    (tb_int),
      .alarm_int (alarm_int),
      .sp_int    (sp_int),
      .flag_n    (flag_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state, kept as plain per-PHI2-cycle event bookkeeping.
   logic [4:0] m_icr;
   logic [4:0] m_imr;
   logic       m_ir;
   logic       m_ir_dly;
   logic       m_flag_prev;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
   endtask

   function automatic logic m_irq_n();
`ifdef CIA_ICR_DELAYED_IRQ_EN
      return ~m_ir_dly;
`else
      return ~m_ir;
`endif
   endfunction

   task automatic model_reset();
      m_icr = '0;
      m_imr = '0;
      m_ir = 1'b0;
      m_ir_dly = 1'b0;
      m_flag_prev = 1'b1;
   endtask

   // One PHI2 cycle: phi2_up strobe, two idle clocks, phi2_dn strobe carrying the access.
   // src bits: 0=TA 1=TB 2=ALRM 3=SP. fl is the FLAG pad level for this cycle.
   task automatic cycle(input logic w, input logic r, input logic [3:0] a,
                        input logic [7:0] d, input logic [3:0] src, input logic fl);
      logic [4:0] ev;
      logic       hit;
      @(negedge clk);
      bus.phi2_up = 1'b1;
      flag_n = fl;
      m_ir_dly = m_ir;
      if ((m_icr & m_imr) != 5'b0) m_ir = 1'b1;
      @(negedge clk);
      bus.phi2_up = 1'b0;
      chk("irq_n_after_up", {7'b0, bus.irq_n}, {7'b0, m_irq_n()});
      chk("regs_after_up", bus.regs, {m_ir, 2'b00, m_icr});
      @(negedge clk);
      @(negedge clk);
      bus.phi2_dn = 1'b1;
      bus.we = w;
      bus.re = r;
      bus.addr = a;
      bus.data = d;
      {sp_int, alarm_int, tb_int, ta_int} = src;
      #1;
      chk(r ? "read_value" : "regs_before_dn", bus.regs, {m_ir, 2'b00, m_icr});
      ev = {m_flag_prev & ~fl, src};
      m_flag_prev = fl;
      hit = (a == 4'hD);
      if (r && hit) begin
         m_icr = ev;
         m_ir = 1'b0;
         m_ir_dly = 1'b0;
      end else begin
         m_icr = m_icr | ev;
      end
      if (w && hit) m_imr = d[7] ? (m_imr | d[4:0]) : (m_imr & ~d[4:0]);
      @(negedge clk);
      bus.phi2_dn = 1'b0;
      bus.we = 1'b0;
      bus.re = 1'b0;
      {sp_int, alarm_int, tb_int, ta_int} = 4'b0;
      chk("regs_after_dn", bus.regs, {m_ir, 2'b00, m_icr});
      chk("irq_n_after_dn", {7'b0, bus.irq_n}, {7'b0, m_irq_n()});
   endtask

   typedef struct {
      logic       w;
      logic       r;
      logic [3:0] a;
      logic [7:0] d;
      logic [3:0] src;
      logic       fl;
      logic [7:0] exp_regs;
   } vec_t;

   vec_t tbl[22];

   initial begin
      res = 1'b1;
      ta_int = 1'b0;
      tb_int = 1'b0;
      alarm_int = 1'b0;
      sp_int = 1'b0;
      flag_n = 1'b1;
      bus.phi2_up = 1'b0;
      bus.phi2_dn = 1'b0;
      bus.we = 1'b0;
      bus.re = 1'b0;
      bus.addr = 4'h0;
      bus.data = 8'h00;
      model_reset();

      //          w     r     addr   data   src      fl    regs after phi2_dn
      tbl[0]  = '{1'b0, 1'b0, 4'hD, 8'h00, 4'b0001, 1'b1, 8'h01}; // TA, masked off
      tbl[1]  = '{1'b0, 1'b1, 4'hD, 8'h00, 4'b0000, 1'b1, 8'h00};
      tbl[2]  = '{1'b1, 1'b0, 4'hD, 8'h88, 4'b0000, 1'b1, 8'h00}; // enable SP
      tbl[3]  = '{1'b0, 1'b0, 4'hD, 8'h00, 4'b1000, 1'b1, 8'h08};
      tbl[4]  = '{1'b0, 1'b0, 4'hD, 8'h00, 4'b0000, 1'b1, 8'h88};
      tbl[5]  = '{1'b0, 1'b1, 4'hD, 8'h00, 4'b0000, 1'b1, 8'h00};
      tbl[6]  = '{1'b0, 1'b0, 4'hD, 8'h00, 4'b0010, 1'b1, 8'h02}; // TB, masked off
      tbl[7]  = '{1'b1, 1'b0, 4'hD, 8'h82, 4'b0000, 1'b1, 8'h02};
      tbl[8]  = '{1'b1, 1'b0, 4'hD, 8'h02, 4'b0000, 1'b1, 8'h82}; // mask clear keeps ir
      tbl[9]  = '{1'b0, 1'b0, 4'hD, 8'h00, 4'b0000, 1'b1, 8'h82};
      tbl[10] = '{1'b0, 1'b1, 4'hD, 8'h00, 4'b0000, 1'b1, 8'h00};
      tbl[11] = '{1'b0, 1'b0, 4'hD, 8'h00, 4'b0001, 1'b1, 8'h01};
      tbl[12] = '{1'b0, 1'b1, 4'hD, 8'h00, 4'b0100, 1'b1, 8'h04}; // read + ALRM together
      tbl[13] = '{1'b0, 1'b1, 4'hD, 8'h00, 4'b0000, 1'b1, 8'h00};
      tbl[14] = '{1'b1, 1'b1, 4'hC, 8'h9F, 4'b0000, 1'b1, 8'h00}; // other address: no effect
      tbl[15] = '{1'b0, 1'b0, 4'hD, 8'h00, 4'b0000, 1'b0, 8'h10}; // FLAG falls
      tbl[16] = '{1'b0, 1'b0, 4'hD, 8'h00, 4'b0000, 1'b0, 8'h10};
      tbl[17] = '{1'b0, 1'b0, 4'hD, 8'h00, 4'b0000, 1'b0, 8'h10};
      tbl[18] = '{1'b0, 1'b1, 4'hD, 8'h00, 4'b0000, 1'b0, 8'h00};
      tbl[19] = '{1'b0, 1'b0, 4'hD, 8'h00, 4'b0000, 1'b1, 8'h00}; // FLAG rises: nothing
      tbl[20] = '{1'b0, 1'b0, 4'hD, 8'h00, 4'b1000, 1'b1, 8'h08};
      tbl[21] = '{1'b0, 1'b0, 4'hD, 8'h00, 4'b0000, 1'b1, 8'h88};

      repeat (3) @(negedge clk);
      chk("reset_regs", bus.regs, 8'h00);
      chk("reset_irq_n", {7'b0, bus.irq_n}, 8'h01);
      res = 1'b0;

      for (int i = 0; i < 22; i++) begin
         cycle(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].src, tbl[i].fl);
         chk($sformatf("vec%0d_regs", i), bus.regs, tbl[i].exp_regs);
      end

      // SP interrupt from tbl[20] is enabled; irq_n must be low here or one cycle later.
      cycle(1'b0, 1'b0, 4'h0, 8'h00, 4'b0000, 1'b1);
      chk("irq_low_before_reset", {7'b0, bus.irq_n}, 8'h00);

      // Asynchronous reset between clock edges, in the middle of a PHI2 cycle.
      @(posedge clk);
      #2;
      res = 1'b1;
      #1;
      chk("async_reset_irq_n", {7'b0, bus.irq_n}, 8'h01);
      chk("async_reset_regs", bus.regs, 8'h00);
      @(negedge clk);
      res = 1'b0;
      model_reset();
      cycle(1'b0, 1'b0, 4'hD, 8'h00, 4'b0001, 1'b1);
      cycle(1'b0, 1'b0, 4'hD, 8'h00, 4'b0000, 1'b1);
      cycle(1'b0, 1'b0, 4'hD, 8'h00, 4'b0000, 1'b1);
      chk("imr_cleared_by_reset", {7'b0, bus.irq_n}, 8'h01);
      chk("ta_after_reset", bus.regs, 8'h01);

      for (int i = 0; i < 250; i++) begin
         logic       w;
         logic       r;
         logic [3:0] a;
         logic [7:0] d;
         logic [3:0] s;
         logic       fl;
         w  = ($urandom_range(0, 3) == 0);
         r  = ($urandom_range(0, 4) == 0);
         a  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hD;
         d  = 8'($urandom);
         s  = 4'($urandom) & 4'($urandom) & 4'($urandom);
         fl = ($urandom_range(0, 2) != 0);
         cycle(w, r, a, d, s, fl);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
